// File: rtl/adder_mp_seq_if.sv
// Word-stream bus for the multi-precision sequential adder: operand words in,
// registered sum words out, each side with its own valid/ready handshake.
interface adder_mp_seq_if #(
    parameter int NBIT = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [NBIT-1:0] i_a;
    logic [NBIT-1:0] i_b;
    logic            i_c;
    logic            o_valid;
    logic            i_ready;
    logic [NBIT-1:0] o_s;
    logic            o_last;
    logic            o_c;
    logic            o_ovf;

    // Upstream producer / downstream consumer side
    modport master (
        output i_valid, i_a, i_b, i_c, i_ready,
        input  o_ready, o_valid, o_s, o_last, o_c, o_ovf
    );

    // Adder side
    modport slave (
        input  i_valid, i_a, i_b, i_c, i_ready,
        output o_ready, o_valid, o_s, o_last, o_c, o_ovf
    );
endinterface

// File: rtl/adder_mp_seq.sv
// Multi-precision sequential adder: one NBIT carry-lookahead adder reused once
// per operand word, LSW first, with the inter-word carry held in a register.

// NBIT-wide adder built from 4-bit lookahead blocks rippled together.
// NBIT must be a multiple of 4.
module adder_cla #(
    parameter int NBIT = 32
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            ci,
    output logic [NBIT-1:0] s,
    output logic            co
);
    localparam int NBLK = NBIT / 4;

    logic [NBLK:0] c;

    assign c[0] = ci;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cc;

        assign g     = a[4*k +: 4] & b[4*k +: 4];
        assign p     = a[4*k +: 4] ^ b[4*k +: 4];
        assign cc[0] = c[k];
        assign cc[1] = g[0] | (p[0] & cc[0]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & cc[0]);
        assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & cc[0]);
        assign s[4*k +: 4] = p ^ cc[3:0];
        assign c[k+1]      = cc[4];
    end

    assign co = c[NBLK];
endmodule

module adder_mp_seq #(
    parameter int NBIT  = 32,
    parameter int NWORD = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    adder_mp_seq_if.slave bus
);
    localparam int              IDX_W    = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORD - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             cr;
    logic             cin;
    logic             ready;
    logic             acc;
    logic             ret;
    logic             is_last;
    logic [NBIT-1:0]  sum;
    logic             co;

    logic             valid_q;
    logic [NBIT-1:0]  s_q;
    logic             last_q;
    logic             c_q;
    logic             ovf_q;

    assign ready   = ~valid_q | bus.i_ready;
    assign acc     = bus.i_valid & ready;
    assign ret     = valid_q & bus.i_ready;
    assign is_last = (idx == IDX_LAST);

    assign bus.o_ready = ready;
    assign bus.o_valid = valid_q;
    assign bus.o_s     = s_q;
    assign bus.o_last  = last_q;
    assign bus.o_c     = c_q;
    assign bus.o_ovf   = ovf_q;

    adder_cla #(.NBIT(NBIT)) u_add (
        .a  (bus.i_a),
        .b  (bus.i_b),
        .ci (cin),
        .s  (sum),
        .co (co)
    );

    // Word counter register; the state is decoded from it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx <= '0;
        end else begin
            idx <= idx_next;
        end
    end

    // State decode, counter advance and carry-in selection
    always_comb begin
        state    = (idx == '0) ? IDLE : BUSY;
        idx_next = idx;
        if (acc) begin
            idx_next = is_last ? '0 : idx + IDX_W'(1);
        end
        cin = (state == IDLE) ? bus.i_c : cr;
    end

    // Inter-word carry and registered output word with its handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            s_q     <= '0;
            last_q  <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            cr      <= 1'b0;
        end else if (acc) begin
            valid_q <= 1'b1;
            s_q     <= sum;
            last_q  <= is_last;
            c_q     <= is_last & co;
            ovf_q   <= is_last & (bus.i_a[NBIT-1] ^ bus.i_b[NBIT-1] ^ sum[NBIT-1] ^ co);
            cr      <= co;
        end else if (ret) begin
            valid_q <= 1'b0;
        end
    end
endmodule
